// File: rtl/dvs_event_packetizer.sv
// DVS event packetizer: turns each popped {x, y, pol, ts} event into 2 or 3 RAVENS
// words, skipping the upper timestamp word while it is unchanged (with periodic refresh).
module dvs_event_packetizer #(
  parameter int DVS_X_ADDR_BITS   = 9,
  parameter int DVS_Y_ADDR_BITS   = 9,
  parameter int TIMESTAMP_US_BITS = 47,
  parameter int RAVENS_PKT_BITS   = 32,
  parameter int TS_HI_REFRESH     = 256
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic [DVS_X_ADDR_BITS+DVS_Y_ADDR_BITS+TIMESTAMP_US_BITS:0] event_i,
  input  logic                                                     event_valid_i,
  output logic                                                     event_ready_o,
  output logic [RAVENS_PKT_BITS-1:0]                               pkt_data_o,
  output logic                                                     pkt_valid_o,
  input  logic                                                     pkt_ready_i,
  output logic                                                     busy_o
);

  // Field positions below are fixed; any other geometry is rejected here.
  if (DVS_X_ADDR_BITS != 9 || DVS_Y_ADDR_BITS != 9 || TIMESTAMP_US_BITS != 47 ||
      RAVENS_PKT_BITS != 32 || TS_HI_REFRESH < 1) begin : g_param_check
    $error("dvs_event_packetizer: unsupported parameter set");
  end

  localparam int CNT_BITS = $clog2(TS_HI_REFRESH + 1);
  localparam logic [CNT_BITS-1:0] REFRESH_MAX = CNT_BITS'(TS_HI_REFRESH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_TS_HI = 2'd2,
    ST_TS_LO = 2'd3
  } state_t;

  function automatic logic [31:0] pack_hdr(input logic hi_f, input logic pol,
                                           input logic [8:0] x, input logic [8:0] y);
    return {2'b11, hi_f, pol, x, y, 10'd0};
  endfunction

  function automatic logic [31:0] pack_ts_hi(input logic [29:0] hi);
    return {2'b10, hi};
  endfunction

  function automatic logic [31:0] pack_ts_lo(input logic [16:0] lo);
    return {2'b01, 13'd0, lo};
  endfunction

  state_t               state_r, state_s;
  logic [46:0]          ev_ts_r;
  logic                 hi_follows_r;
  logic                 hi_known_r;
  logic [29:0]          last_hi_r;
  logic [CNT_BITS-1:0]  refresh_cnt_r;
  logic [31:0]          pkt_data_r, pkt_data_s;
  logic                 pkt_valid_r, pkt_valid_s;
  logic                 event_ready_s;
  logic                 ev_take_s;
  logic                 pkt_fire_s;
  logic                 hi_follows_s;

  assign pkt_fire_s   = pkt_valid_r & pkt_ready_i;
  assign ev_take_s    = event_valid_i & event_ready_s;
  assign hi_follows_s = !hi_known_r || (event_i[46:17] != last_hi_r) ||
                        (refresh_cnt_r == REFRESH_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ev_take_s) state_s = ST_HDR;
        else           state_s = ST_IDLE;
      end
      ST_HDR: begin
        if (pkt_fire_s) state_s = hi_follows_r ? ST_TS_HI : ST_TS_LO;
        else            state_s = ST_HDR;
      end
      ST_TS_HI: begin
        if (pkt_fire_s) state_s = ST_TS_LO;
        else            state_s = ST_TS_HI;
      end
      ST_TS_LO: begin
        if (pkt_fire_s) state_s = ev_take_s ? ST_HDR : ST_IDLE;
        else            state_s = ST_TS_LO;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output logic: pop condition and the next packet word to present
  always_comb begin
    event_ready_s = !rst && ((state_r == ST_IDLE) || (state_r == ST_TS_LO && pkt_ready_i));
    pkt_data_s    = pkt_data_r;
    pkt_valid_s   = pkt_valid_r;
    if (ev_take_s) begin
      pkt_data_s  = pack_hdr(hi_follows_s, event_i[47], event_i[65:57], event_i[56:48]);
      pkt_valid_s = 1'b1;
    end else if (pkt_fire_s) begin
      case (state_r)
        ST_HDR: begin
          pkt_valid_s = 1'b1;
          if (hi_follows_r) pkt_data_s = pack_ts_hi(ev_ts_r[46:17]);
          else              pkt_data_s = pack_ts_lo(ev_ts_r[16:0]);
        end
        ST_TS_HI: begin
          pkt_valid_s = 1'b1;
          pkt_data_s  = pack_ts_lo(ev_ts_r[16:0]);
        end
        default: begin
          pkt_valid_s = 1'b0;
          pkt_data_s  = 32'd0;
        end
      endcase
    end else begin
      pkt_data_s  = pkt_data_r;
      pkt_valid_s = pkt_valid_r;
    end
  end

  // Packet output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_data_r  <= 32'd0;
      pkt_valid_r <= 1'b0;
    end else begin
      pkt_data_r  <= pkt_data_s;
      pkt_valid_r <= pkt_valid_s;
    end
  end

  // Event latch and upper-timestamp tracking; tracking commits when the HDR word leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_ts_r       <= 47'd0;
      hi_follows_r  <= 1'b0;
      hi_known_r    <= 1'b0;
      last_hi_r     <= 30'd0;
      refresh_cnt_r <= '0;
    end else begin
      if (ev_take_s) begin
        ev_ts_r      <= event_i[46:0];
        hi_follows_r <= hi_follows_s;
      end
      if (state_r == ST_HDR && pkt_fire_s) begin
        if (hi_follows_r) begin
          last_hi_r     <= ev_ts_r[46:17];
          hi_known_r    <= 1'b1;
          refresh_cnt_r <= '0;
        end else if (refresh_cnt_r < REFRESH_MAX) begin
          refresh_cnt_r <= refresh_cnt_r + CNT_BITS'(1);
        end
      end
    end
  end

  assign event_ready_o = event_ready_s;
  assign pkt_data_o    = pkt_data_r;
  assign pkt_valid_o   = pkt_valid_r;
  assign busy_o        = (state_r != ST_IDLE);

endmodule
